// File: rtl/i2c_datapath_if.sv
// ---------------------------------------------------------------------------
// i2c_datapath_if
//   Bundles the control/bus signals between the I2C control FSM (master
//   modport) and the bit-level datapath (slave modport).
//
//   Controller -> datapath : state, scl_ena, addr, rw, wr_data, rd_more,
//                            sda_in, scl_in (only with I2C_DP_CLK_STRETCH_EN)
//   Datapath -> controller : scl, sda_oe, scl_p, scl_n, counter, st_ena,
//                            rd_data, rd_valid
//
//   Optional feature macro: I2C_DP_CLK_STRETCH_EN adds scl_in.
// ---------------------------------------------------------------------------
interface i2c_datapath_if;
    logic [3:0] state;
    logic       scl_ena;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wr_data;
    logic       rd_more;
    logic       sda_in;
    logic       scl;
    logic       sda_oe;
    logic       scl_p;
    logic       scl_n;
    logic       counter;
    logic       st_ena;
    logic [7:0] rd_data;
    logic       rd_valid;

`ifdef I2C_DP_CLK_STRETCH_EN
    logic       scl_in;

    modport master (
        output state, scl_ena, addr, rw, wr_data, rd_more, sda_in, scl_in,
        input  scl, sda_oe, scl_p, scl_n, counter, st_ena, rd_data, rd_valid
    );
    modport slave (
        input  state, scl_ena, addr, rw, wr_data, rd_more, sda_in, scl_in,
        output scl, sda_oe, scl_p, scl_n, counter, st_ena, rd_data, rd_valid
    );
`else
    modport master (
        output state, scl_ena, addr, rw, wr_data, rd_more, sda_in,
        input  scl, sda_oe, scl_p, scl_n, counter, st_ena, rd_data, rd_valid
    );
    modport slave (
        input  state, scl_ena, addr, rw, wr_data, rd_more, sda_in,
        output scl, sda_oe, scl_p, scl_n, counter, st_ena, rd_data, rd_valid
    );
`endif
endinterface

// File: rtl/i2c_datapath.sv
// ---------------------------------------------------------------------------
// i2c_datapath
//   Bit-level I2C master datapath: quarter-period SCL generator, SDA drive
//   control, shift register for address/write/read bytes and bit counter.
//   The control FSM lives outside and presents its state on bus.state.
//
//   Parameters : CLK_DIV  clk cycles per quarter SCL period (2..1023)
//   Ports      : clk      system clock (rising edge)
//                rst_n    asynchronous active-low reset
//                bus      i2c_datapath_if.slave (see interface header)
//
//   Optional feature macro: I2C_DP_CLK_STRETCH_EN -- holds the quarter
//   divider in phase 1 while the slave keeps SCL low (bus.scl_in = 0).
// ---------------------------------------------------------------------------
module i2c_datapath #(
    parameter int CLK_DIV = 125
) (
    input  logic           clk,
    input  logic           rst_n,
    i2c_datapath_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START      = 4'd1,
        ST_ADDRESS    = 4'd2,
        ST_READ_ACK   = 4'd3,
        ST_WRITE      = 4'd4,
        ST_READ       = 4'd5,
        ST_READ_ACK_1 = 4'd6,
        ST_WRITE_ACK  = 4'd7,
        ST_STOP       = 4'd8
    } state_e;

    localparam int                DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q,      div_d;
    logic [1:0]       phase_q,    phase_d;
    logic [3:0]       state_q,    state_d;
    logic [7:0]       shreg_q,    shreg_d;
    logic [2:0]       bitcnt_q,   bitcnt_d;
    logic             scl_q,      scl_d;
    logic             sda_oe_q,   sda_oe_d;
    logic             st_ena_q,   st_ena_d;
    logic [7:0]       rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic hold;
    logic tick;
    logic scl_p;
    logic scl_n;
    logic adv_12;
    logic changed;

`ifdef I2C_DP_CLK_STRETCH_EN
    // Slave clock stretching: while we release SCL in phase 1, a low SCL
    // line means the slave is holding it, so time stops until it lets go.
    assign hold = (phase_q == 2'd1) && !bus.scl_ena && !bus.scl_in;
`else
    assign hold = 1'b0;
`endif

    assign tick    = !hold && (div_q == DIV_MAX);
    assign scl_p   = tick && (phase_q == 2'd0);
    assign scl_n   = tick && (phase_q == 2'd2);
    assign adv_12  = tick && (phase_q == 2'd1);
    // state_q trails the controller's state by one clk, so a mismatch marks
    // the first clk after a state change.
    assign changed = (bus.state != state_q);

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        div_d      = div_q;
        phase_d    = phase_q;
        state_d    = bus.state;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        st_ena_d   = st_ena_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        sda_oe_d   = 1'b0;

        if (!hold) begin
            if (div_q == DIV_MAX) begin
                div_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                div_d   = div_q + DIV_W'(1);
            end
        end
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);

        // A state change wins over any shift or count on the same clk so the
        // new byte always starts from a clean load.
        if (changed) begin
            bitcnt_d = '0;
            st_ena_d = 1'b0;
            if (bus.state == ST_ADDRESS) begin
                shreg_d = {bus.addr, bus.rw};
            end else if (bus.state == ST_WRITE) begin
                shreg_d = bus.wr_data;
            end
        end else begin
            case (bus.state)
                ST_START: begin
                    if (adv_12) st_ena_d = 1'b1;
                end
                ST_ADDRESS, ST_WRITE: begin
                    if (scl_n) begin
                        shreg_d  = {shreg_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                ST_READ: begin
                    if (scl_p) shreg_d = {shreg_q[6:0], bus.sda_in};
                    if (scl_n) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rd_data_d  = shreg_q;
                            rd_valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // sda_oe is computed from next-state values so the registered pin
        // lines up exactly with the shift register and phase flops.
        case (bus.state)
            ST_START:             sda_oe_d = st_ena_d;
            ST_ADDRESS, ST_WRITE: sda_oe_d = ~shreg_d[7];
            ST_WRITE_ACK:         sda_oe_d = ~bus.rd_more;
            ST_STOP:              sda_oe_d = (phase_d != 2'd2);
            default:              sda_oe_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            phase_q    <= 2'd0;
            state_q    <= ST_IDLE;
            shreg_q    <= 8'h00;
            bitcnt_q   <= 3'd0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            st_ena_q   <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            st_ena_q   <= st_ena_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.scl      = scl_q | bus.scl_ena;
    assign bus.sda_oe   = sda_oe_q;
    assign bus.scl_p    = scl_p;
    assign bus.scl_n    = scl_n;
    assign bus.counter  = ((bus.state == ST_ADDRESS) || (bus.state == ST_WRITE) ||
                           (bus.state == ST_READ)) && (bitcnt_q == 3'd7);
    assign bus.st_ena   = st_ena_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule
